// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for issue/hazard control
package cpu_pkg;

  localparam int RADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] dst;
    logic               reg_write;
    logic               is_load;
  } slot_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hctl_state_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - compares one shadow-pipeline slot against one source operand
module hazard_match
  import cpu_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  slot_t              slot,
  input  logic [RADDR_W-1:0] src,
  input  logic               src_used,
  output logic               match
);

  logic src_is_zero;

  assign src_is_zero = ZERO_REG && (src == '0);
  assign match = slot.valid && slot.reg_write && (slot.dst == src) && src_used && !src_is_zero;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// rtl/issue_hazard_ctrl.sv - issue sequencing with forwarding selects, load-use stall,
// branch flush and halt drain
module issue_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic [RADDR_W-1:0] dec_src1,
  input  logic               dec_src1_used,
  input  logic [RADDR_W-1:0] dec_src2,
  input  logic               dec_src2_used,
  input  logic [RADDR_W-1:0] dec_dst,
  input  logic               dec_reg_write,
  input  logic               dec_is_load,
  input  logic               dec_is_halt,
  input  logic               ex_do_branch,
  output logic               issue,
  output logic               stall,
  output logic               flush,
  output logic [1:0]         fwd1_sel,
  output logic [1:0]         fwd2_sel,
  output logic               halted
);

  localparam int CNT_W = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;

  hctl_state_t      state_q, state_d;
  slot_t            ex_slot_q, ex_slot_d;
  slot_t            mem_slot_q, mem_slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fwd_sel_t         fwd1_q, fwd1_d;
  fwd_sel_t         fwd2_q, fwd2_d;
  logic             halted_q, halted_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;

  hazard_match #(.ZERO_REG(ZERO_REG)) u_ex_s1  (.slot(ex_slot_q),  .src(dec_src1), .src_used(dec_src1_used), .match(ex_m1));
  hazard_match #(.ZERO_REG(ZERO_REG)) u_ex_s2  (.slot(ex_slot_q),  .src(dec_src2), .src_used(dec_src2_used), .match(ex_m2));
  hazard_match #(.ZERO_REG(ZERO_REG)) u_mem_s1 (.slot(mem_slot_q), .src(dec_src1), .src_used(dec_src1_used), .match(mem_m1));
  hazard_match #(.ZERO_REG(ZERO_REG)) u_mem_s2 (.slot(mem_slot_q), .src(dec_src2), .src_used(dec_src2_used), .match(mem_m2));

  always_comb begin
    flush = ex_do_branch || (cnt_q != '0);
    stall = dec_valid && (state_q == RUN) && ex_slot_q.is_load && (ex_m1 || ex_m2) && !flush;
    issue = dec_valid && (state_q == RUN) && !stall && !flush;
  end

  always_comb begin
    mem_slot_d = ex_slot_q;
    ex_slot_d  = '0;
    if (issue) begin
      ex_slot_d.valid     = 1'b1;
      ex_slot_d.dst       = dec_dst;
      ex_slot_d.reg_write = dec_reg_write;
      ex_slot_d.is_load   = dec_is_load;
    end

    cnt_d = cnt_q;
    if (ex_do_branch) begin
      cnt_d = CNT_W'(BR_PENALTY - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    // youngest writer (EX) wins over MEM
    fwd1_d = FWD_REG;
    fwd2_d = FWD_REG;
    if (issue) begin
      fwd1_d = ex_m1 ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_REG);
      fwd2_d = ex_m2 ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_REG);
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      RUN: begin
        if (issue && dec_is_halt) state_d = DRAIN;
      end
      DRAIN: begin
        // a branch here means the halt was fetched down the wrong path
        if (ex_do_branch) begin
          state_d = RUN;
        end else if (!ex_slot_d.valid && !mem_slot_d.valid) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      ex_slot_q  <= '0;
      mem_slot_q <= '0;
      cnt_q      <= '0;
      fwd1_q     <= FWD_REG;
      fwd2_q     <= FWD_REG;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_slot_q  <= ex_slot_d;
      mem_slot_q <= mem_slot_d;
      cnt_q      <= cnt_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      halted_q   <= halted_d;
    end
  end

  assign fwd1_sel = fwd1_q;
  assign fwd2_sel = fwd2_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb/tb_issue_hazard_ctrl.sv - directed self-checking bench for issue_hazard_ctrl
module tb_issue_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [3:0] dec_src1;
  logic       dec_src1_used;
  logic [3:0] dec_src2;
  logic       dec_src2_used;
  logic [3:0] dec_dst;
  logic       dec_reg_write;
  logic       dec_is_load;
  logic       dec_is_halt;
  logic       ex_do_branch;
  logic       issue;
  logic       stall;
  logic       flush;
  logic [1:0] fwd1_sel;
  logic [1:0] fwd2_sel;
  logic       halted;

  int n_checks = 0;
  int n_pass   = 0;

  issue_hazard_ctrl #(.BR_PENALTY(2), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src1_used(dec_src1_used),
    .dec_src2(dec_src2), .dec_src2_used(dec_src2_used),
    .dec_dst(dec_dst), .dec_reg_write(dec_reg_write),
    .dec_is_load(dec_is_load), .dec_is_halt(dec_is_halt),
    .ex_do_branch(ex_do_branch),
    .issue(issue), .stall(stall), .flush(flush),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drv(input logic v, input logic [3:0] s1, input logic u1,
                     input logic [3:0] s2, input logic u2, input logic [3:0] d,
                     input logic rw, input logic ld, input logic hlt, input logic br);
    dec_valid = v; dec_src1 = s1; dec_src1_used = u1; dec_src2 = s2; dec_src2_used = u2;
    dec_dst = d; dec_reg_write = rw; dec_is_load = ld; dec_is_halt = hlt; ex_do_branch = br;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();
    check("rst_fwd1", fwd1_sel, 0);
    check("rst_fwd2", fwd2_sel, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    #1;
    check("rst_flush", flush, 0);
    check("rst_stall", stall, 0);

    // EX forwarding on src1
    drv(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0, 0, 0);
    check("t1_issue_w", issue, 1);
    tick();
    drv(1, 4'd1, 1, 4'd9, 1, 4'd10, 1, 0, 0, 0);
    check("t1_issue_r", issue, 1);
    check("t1_stall", stall, 0);
    tick();
    idle();
    check("t1_fwd1", fwd1_sel, 1);
    check("t1_fwd2", fwd2_sel, 0);
    tick();
    check("t1_fwd1_clr", fwd1_sel, 0);
    tick();

    // MEM forwarding on src2
    drv(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0); tick();
    drv(1, 4'd9, 0, 4'd2, 1, 4'd11, 1, 0, 0, 0);
    check("t2_issue", issue, 1);
    tick(); idle();
    check("t2_fwd2", fwd2_sel, 2);
    tick(); tick();

    // r0 never forwarded
    drv(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0); tick();
    drv(1, 4'd9, 0, 4'd0, 1, 4'd11, 1, 0, 0, 0); tick(); idle();
    check("t3_fwd2_r0", fwd2_sel, 0);
    tick(); tick();

    // load-use stall
    drv(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0, 0); tick();
    drv(1, 4'd3, 1, 4'd0, 0, 4'd12, 1, 0, 0, 0);
    check("t4_stall", stall, 1);
    check("t4_issue_stalled", issue, 0);
    tick();
    check("t4_stall_once", stall, 0);
    check("t4_issue_after", issue, 1);
    check("t4_fwd1_stallcyc", fwd1_sel, 0);
    tick(); idle();
    check("t4_fwd1", fwd1_sel, 2);
    tick(); tick();

    // both slots write r4: EX wins
    drv(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0, 0); tick();
    drv(1, 4'd4, 1, 4'd0, 0, 4'd13, 1, 0, 0, 0); tick(); idle();
    check("t5_fwd1_ex_prio", fwd1_sel, 1);
    tick(); tick();

    // branch penalty
    drv(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 1);
    check("t6_flush_t", flush, 1);
    check("t6_issue_t", issue, 0);
    tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 0);
    check("t6_flush_t1", flush, 1);
    check("t6_issue_t1", issue, 0);
    tick();
    check("t6_flush_t2", flush, 0);
    check("t6_issue_t2", issue, 1);
    idle(); tick(); tick(); tick();

    // load-use coinciding with branch
    drv(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd5, 1, 4'd14, 1, 0, 0, 1);
    check("t7_stall", stall, 0);
    check("t7_flush", flush, 1);
    tick(); idle(); tick(); tick();

    // halt drain behind two writers
    drv(1, 4'd0, 0, 4'd0, 0, 4'd6, 1, 0, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
    check("t8_halt_issue", issue, 1);
    tick(); idle();
    check("t8_halted_d0", halted, 0);
    tick();
    check("t8_halted_d1", halted, 0);
    tick();
    check("t8_halted", halted, 1);
    drv(1, 4'd0, 0, 4'd0, 0, 4'd8, 1, 0, 0, 0);
    check("t8_no_issue", issue, 0);
    tick();
    check("t8_halted_hold", halted, 1);

    rst = 1'b1; idle(); tick(); rst = 1'b0; #1;

    // wrong-path halt cancelled by branch
    drv(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0); tick();
    drv(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1);
    check("t9_flush", flush, 1);
    tick(); idle(); tick(); tick();
    check("t9_halted", halted, 0);
    drv(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 0, 0, 0);
    check("t9_run_issue", issue, 1);
    tick(); idle(); tick(); tick();

    // reset during DRAIN
    drv(1, 4'd0, 0, 4'd0, 0, 4'd8, 1, 1, 0, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0); tick();
    drv(1, 4'd8, 1, 4'd0, 0, 4'd0, 0, 0, 1, 0); tick();
    drv(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0, 0, 0);
    check("t10_fwd1_pre", fwd1_sel, 2);
    check("t10_drain_no_issue", issue, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    drv(1, 4'd0, 1, 4'd0, 0, 4'd1, 1, 0, 0, 0);
    check("t10_halted", halted, 0);
    check("t10_fwd1", fwd1_sel, 0);
    check("t10_fwd2", fwd2_sel, 0);
    check("t10_stall", stall, 0);
    check("t10_issue_v1", issue, 1);
    idle();
    check("t10_issue_v0", issue, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
